// File: rtl/uart_cfg_pkg.sv
// Shared encodings for the configurable UART: parity modes, TX/RX FSM states,
// default oversampling ratio and the data-width/parity helpers used by both directions.
package uart_cfg_pkg;

  localparam int OSR_DEFAULT = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // The reserved parity encoding behaves exactly like "none".
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // dbits selects 5..8 data bits; mask keeps only the transmitted ones.
  function automatic logic [7:0] dbits_mask(input logic [1:0] dbits);
    return 8'hFF >> (2'd3 - dbits);
  endfunction

  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] dbits,
                                       input logic [1:0] mode);
    return (^(data & dbits_mask(dbits))) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-cycle tick every baud_div+1 clocks.
module uart_baud_gen #(
  parameter int DIV_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  // >= keeps the counter bounded if baud_div is lowered while running.
  assign tick = (r_cnt >= baud_div);

  always_ff @(posedge clk) begin
    if (reset)     r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/baud_cfg_uart.sv
// Full-duplex UART with run-time data width, parity and stop-bit selection.
// TX latches its frame config on accept; RX latches it on start-bit detection.
module baud_cfg_uart
  import uart_cfg_pkg::*;
#(
  parameter int OSR   = OSR_DEFAULT,
  parameter int DIV_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_dbits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [1:0]       rx_err,
  output logic             rx_overrun,
  input  logic             ovr_clr
);

  localparam int CW = $clog2(2 * OSR);
  localparam logic [CW-1:0] BIT_LAST   = CW'(OSR - 1);
  localparam logic [CW-1:0] STOP2_LAST = CW'(2 * OSR - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(OSR / 2 - 1);

  logic w_tick;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .baud_div (baud_div),
    .tick     (w_tick)
  );

  // Handshakes: a transfer happens on a cycle where valid && ready are both high;
  // valid never depends on ready, and offered data is held stable until transferred.

  tx_state_e      r_tx_state, w_tx_next;
  logic [CW-1:0]  r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]     r_tx_bit, w_tx_bit_nx, w_tx_bit_last;
  logic [7:0]     r_tx_shift;
  logic [1:0]     r_tx_dbits;
  logic           r_tx_par, r_tx_par_en, r_tx_stop2;
  logic           w_tx_accept, w_tx_shift_en;

  assign w_tx_bit_last = {1'b0, r_tx_dbits} + 3'd4;

  always_comb begin
    w_tx_next     = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_en = 1'b0;
    w_tx_accept   = 1'b0;
    tx_ready      = 1'b0;
    tx            = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          w_tx_accept = 1'b1;
          w_tx_cnt_nx = '0;
          w_tx_next   = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (w_tick) begin
          if (r_tx_cnt == BIT_LAST) begin
            w_tx_cnt_nx = '0;
            w_tx_bit_nx = '0;
            w_tx_next   = TX_DATA;
          end else w_tx_cnt_nx = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        tx = r_tx_shift[0];
        if (w_tick) begin
          if (r_tx_cnt == BIT_LAST) begin
            w_tx_cnt_nx   = '0;
            w_tx_shift_en = 1'b1;
            w_tx_bit_nx   = r_tx_bit + 1'b1;
            if (r_tx_bit == w_tx_bit_last) w_tx_next = r_tx_par_en ? TX_PARITY : TX_STOP;
          end else w_tx_cnt_nx = r_tx_cnt + 1'b1;
        end
      end
      TX_PARITY: begin
        tx = r_tx_par;
        if (w_tick) begin
          if (r_tx_cnt == BIT_LAST) begin
            w_tx_cnt_nx = '0;
            w_tx_next   = TX_STOP;
          end else w_tx_cnt_nx = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_tx_cnt == (r_tx_stop2 ? STOP2_LAST : BIT_LAST)) begin
            w_tx_cnt_nx = '0;
            w_tx_next   = TX_IDLE;
          end else w_tx_cnt_nx = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state  <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_shift  <= '0;
      r_tx_par    <= 1'b0;
      r_tx_dbits  <= '0;
      r_tx_par_en <= 1'b0;
      r_tx_stop2  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      if (w_tx_accept) begin
        r_tx_shift  <= tx_data & dbits_mask(cfg_dbits);
        r_tx_par    <= calc_parity(tx_data, cfg_dbits, cfg_parity);
        r_tx_dbits  <= cfg_dbits;
        r_tx_par_en <= par_enabled(cfg_parity);
        r_tx_stop2  <= cfg_stop2;
      end else if (w_tx_shift_en) begin
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
      end
    end
  end

  logic [1:0]     r_rx_sync;
  logic           w_rx_s;
  rx_state_e      r_rx_state, w_rx_next;
  logic [CW-1:0]  r_rx_cnt, w_rx_cnt_nx;
  logic [2:0]     r_rx_bit, w_rx_bit_nx, w_rx_bit_last;
  logic [7:0]     r_rx_shift;
  logic [1:0]     r_rx_dbits, r_rx_mode;
  logic           r_rx_par;
  logic           w_rx_start, w_rx_data_smp, w_rx_par_smp, w_rx_done;
  logic [1:0]     w_rx_err;
  logic [7:0]     r_rx_data;
  logic [1:0]     r_rx_err;
  logic           r_rx_valid, r_rx_overrun;

  assign w_rx_s        = r_rx_sync[1];
  assign w_rx_bit_last = {1'b0, r_rx_dbits} + 3'd4;
  // Evaluated on the stop-bit sample cycle, where w_rx_s is the stop bit itself.
  assign w_rx_err = {~w_rx_s,
                     par_enabled(r_rx_mode) &&
                     (r_rx_par != calc_parity(r_rx_shift, r_rx_dbits, r_rx_mode))};

  always_comb begin
    w_rx_next     = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_start    = 1'b0;
    w_rx_data_smp = 1'b0;
    w_rx_par_smp  = 1'b0;
    w_rx_done     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!w_rx_s) begin
          w_rx_start  = 1'b1;
          w_rx_cnt_nx = '0;
          w_rx_next   = RX_START;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rx_cnt == HALF_LAST) begin
            w_rx_cnt_nx = '0;
            w_rx_bit_nx = '0;
            w_rx_next   = w_rx_s ? RX_IDLE : RX_DATA;
          end else w_rx_cnt_nx = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_rx_cnt == BIT_LAST) begin
            w_rx_cnt_nx   = '0;
            w_rx_data_smp = 1'b1;
            w_rx_bit_nx   = r_rx_bit + 1'b1;
            if (r_rx_bit == w_rx_bit_last)
              w_rx_next = par_enabled(r_rx_mode) ? RX_PARITY : RX_STOP;
          end else w_rx_cnt_nx = r_rx_cnt + 1'b1;
        end
      end
      RX_PARITY: begin
        if (w_tick) begin
          if (r_rx_cnt == BIT_LAST) begin
            w_rx_cnt_nx  = '0;
            w_rx_par_smp = 1'b1;
            w_rx_next    = RX_STOP;
          end else w_rx_cnt_nx = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_rx_cnt == BIT_LAST) begin
            w_rx_cnt_nx = '0;
            w_rx_done   = 1'b1;
            w_rx_next   = RX_IDLE;
          end else w_rx_cnt_nx = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_sync    <= 2'b11;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_dbits   <= '0;
      r_rx_mode    <= '0;
      r_rx_par     <= 1'b0;
      r_rx_data    <= '0;
      r_rx_err     <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], rx};
      r_rx_state <= w_rx_next;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      if (w_rx_start) begin
        r_rx_shift <= '0;
        r_rx_dbits <= cfg_dbits;
        r_rx_mode  <= cfg_parity;
      end else if (w_rx_data_smp) begin
        r_rx_shift[r_rx_bit] <= w_rx_s;
      end
      if (w_rx_par_smp) r_rx_par <= w_rx_s;
      // A completed frame only overwrites the holding register if it is free this cycle.
      if (w_rx_done && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= r_rx_shift;
        r_rx_err   <= w_rx_err;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done && r_rx_valid && !rx_ready) r_rx_overrun <= 1'b1;
      else if (ovr_clr)                         r_rx_overrun <= 1'b0;
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_err     = r_rx_err;
  assign rx_valid   = r_rx_valid;
  assign rx_overrun = r_rx_overrun;

endmodule

// File: doc/baud_cfg_uart.md
BAUD_CFG_UART -- requirements
Module: baud_cfg_uart

Interface
REQ-001 SHALL have parameter OSR, default 16, oversampling ticks per bit (even, >=8).
REQ-002 SHALL have parameter DIV_W, default 11, width of the baud divisor.
REQ-003 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port baud_div  in  DIV_W  tick period minus one.
REQ-006 SHALL have port cfg_dbits  in  2  data bits = 5 + cfg_dbits (5..8).
REQ-007 SHALL have port cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 SHALL have port cfg_stop2  in  1  1 = two stop bits transmitted.
REQ-009 SHALL have port tx_data  in  8  TX byte, LSB first; bits above cfg_dbits ignored.
REQ-010 SHALL have port tx_valid  in  1  TX data offered.
REQ-011 SHALL have port tx_ready  out  1  transmitter idle, accepts tx_data.
REQ-012 SHALL have port tx  out  1  serial output, idle high.
REQ-013 SHALL have port rx  in  1  asynchronous serial input.
REQ-014 SHALL have port rx_data  out  8  received word, zero-extended.
REQ-015 SHALL have port rx_valid  out  1  rx_data/rx_err held and valid.
REQ-016 SHALL have port rx_ready  in  1  consumer accepts rx_data.
REQ-017 SHALL have port rx_err  out  2  {frame_err, parity_err} of the held word.
REQ-018 SHALL have port rx_overrun  out  1  sticky: a frame was dropped.
REQ-019 SHALL have port ovr_clr  in  1  clears rx_overrun.

Function
REQ-020 Baud counter SHALL count 0..baud_div, pulse tick for one cycle at baud_div, then wrap to 0; baud_div=0 SHALL tick every cycle.
REQ-021 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; tx_ready=1 only in IDLE.
REQ-022 On tx_valid&&tx_ready, TX SHALL latch tx_data and all cfg_* inputs and enter START next cycle; cfg changes mid-frame SHALL have no effect.
REQ-023 Each TX bit SHALL last exactly OSR ticks: start=0, data LSB first, parity if enabled, then OSR (cfg_stop2=0) or 2*OSR (cfg_stop2=1) stop ticks at 1, then IDLE.
REQ-024 Parity SHALL cover only the cfg_dbits-selected bits: even => XOR of data bits, odd => its inverse.
REQ-025 rx SHALL pass a 2-flop synchroniser (reset value 1) before any use.
REQ-026 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; synced 0 in IDLE SHALL enter START and reset the tick count.
REQ-027 RX SHALL resample at tick OSR/2-1 of START; if 1, return to IDLE with no output (glitch rejected).
REQ-028 RX SHALL sample data, parity and the first stop bit every OSR ticks thereafter (mid-bit); one stop bit is checked regardless of cfg_stop2.
REQ-029 RX SHALL return to IDLE on the stop-bit sample cycle, allowing back-to-back frames.
REQ-030 frame_err SHALL be set when the sampled stop bit is 0; parity_err when received parity mismatches the computed parity; both 0 when parity is none.
REQ-031 On frame completion with rx_valid=0, or rx_valid&&rx_ready in the same cycle, rx_data/rx_err SHALL load and rx_valid SHALL be 1 next cycle.
REQ-032 On frame completion with rx_valid=1 and rx_ready=0, the new frame SHALL be dropped, held data kept, and rx_overrun set.
REQ-033 rx_valid SHALL clear on rx_valid&&rx_ready absent a simultaneous completion; ovr_clr SHALL clear rx_overrun unless an overrun occurs the same cycle (set wins).

Reset
REQ-034 reset SHALL force both FSMs to IDLE and the baud counter to 0; tx=1, tx_ready=1, rx_valid=0, rx_data=0, rx_err=0, rx_overrun=0 at the next edge, including mid-frame.
REQ-035 The first TX frame after reset SHALL start no earlier than the cycle after reset deasserts.

Structure
REQ-036 Package uart_cfg_pkg SHALL hold the parity-mode encoding, the TX/RX state enums and the default OSR constant.
REQ-037 Baud divider SHALL be the sub-module uart_baud_gen (inputs clk, reset, baud_div; output tick).

Verification
REQ-038 baud_div=0, 8N1, tx_data=0xA5 -> tx: 16 cycles 0, bits 1,0,1,0,0,1,0,1 at 16 cycles each, 16 cycles 1; tx_ready high again 160 cycles after the start bit.
REQ-039 7E2, tx_data=0x41 -> 7 data bits 1000001, parity bit 0, 32 stop cycles; 7O1 same data -> parity bit 1.
REQ-040 tx looped to rx, 8N1, bytes 0x00, 0xFF, 0x5A back-to-back, rx_ready=1 -> three rx_valid pulses with matching data, rx_err=00.
REQ-041 rx low 4 cycles then high -> no rx_valid; stop bit driven 0 -> rx_valid with rx_err=10; wrong parity in 8E1 -> rx_err=01.
REQ-042 rx_ready=0, two frames 0x11, 0x22 -> rx_data=0x11 held, rx_overrun=1; ovr_clr pulse -> rx_overrun=0.
REQ-043 reset asserted mid-TX data bit -> tx=1, tx_ready=1 next cycle; subsequent 0x3C frame transmits correctly.
